ucc_stack_guard: RTL and testbench

- Parametrised successor to the single-region stack protector.
- Tracks nested entry into up to DEPTH untrusted-code-container (UCC) regions, each identified by a ucc_id.
- Keeps a LIFO of saved base pointers (ebp) and region ids. Enforces write-below-frame, stack-floor, exact-SP-on-return and nesting-depth rules.
- Drives a sticky reset request to the MCU reset logic, with a recorded violation cause.

---
 rtl/ucc_guard_pkg.sv | 26 ++
 rtl/ucc_stack_guard_lifo.sv | 78 +++++++
 rtl/ucc_stack_guard.sv | 163 ++++++++++++++++
 tb/tb_ucc_stack_guard.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ucc_guard_pkg.sv
// ucc_guard_pkg
//   Shared definitions for the UCC stack guard: FSM state encoding,
//   violation cause codes and the depth-counter width helper.
//   No ports; imported by ebp_lifo and ucc_stack_guard.
package ucc_guard_pkg;

   typedef enum logic [1:0] {
      STATE_IDLE   = 2'b00,
      STATE_ACTIVE = 2'b01,
      STATE_VIOL   = 2'b11
   } state_t;

   typedef enum logic [2:0] {
      CAUSE_NONE         = 3'd0,
      CAUSE_WRITE        = 3'd1,
      CAUSE_SP_MISMATCH  = 3'd2,
      CAUSE_ILLEGAL_EXIT = 3'd3,
      CAUSE_OVERFLOW     = 3'd4
   } cause_t;

   // Bits needed to count 0..depth inclusive.
   function automatic int depth_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/ucc_stack_guard_lifo.sv
// ebp_lifo
//   LIFO of saved {ebp, region id} pairs, one entry per nesting level.
//   Ports:
//     i_clk               clock
//     i_push/i_pop        push {i_ebp,i_id} / drop the top entry
//     i_clear             synchronous clear of all entries (highest priority)
//     o_top_ebp/o_top_id  top entry (0 when empty)
//     o_below_id          id of the entry below the top (0 when depth<2)
//     o_depth             number of valid entries
//     o_full/o_empty      occupancy flags
//   A push while full is dropped; the caller flags overflow instead.
module ebp_lifo
   import ucc_guard_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int ID_W   = 3,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = depth_w(DEPTH)
) (
   input  logic              i_clk,
   input  logic              i_push,
   input  logic              i_pop,
   input  logic              i_clear,
   input  logic [ADDR_W-1:0] i_ebp,
   input  logic [ID_W-1:0]   i_id,
   output logic [ADDR_W-1:0] o_top_ebp,
   output logic [ID_W-1:0]   o_top_id,
   output logic [ID_W-1:0]   o_below_id,
   output logic [CNT_W-1:0]  o_depth,
   output logic              o_full,
   output logic              o_empty
);

   logic [ADDR_W-1:0] r_ebp [DEPTH];
   logic [ID_W-1:0]   r_id  [DEPTH];
   logic [CNT_W-1:0]  r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_clear) begin
         r_cnt <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_ebp[i] <= '0;
            r_id[i]  <= '0;
         end
      end else if (i_push && !o_full) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (i == int'(r_cnt)) begin
               r_ebp[i] <= i_ebp;
               r_id[i]  <= i_id;
            end
         end
         r_cnt <= r_cnt + CNT_W'(1);
      end else if (i_pop && !o_empty) begin
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   // Loop-based read mux keeps indexing legal for every DEPTH, including 1.
   always_comb begin
      o_top_ebp  = '0;
      o_top_id   = '0;
      o_below_id = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (int'(r_cnt) == i + 1) begin
            o_top_ebp = r_ebp[i];
            o_top_id  = r_id[i];
         end
         if (int'(r_cnt) == i + 2) begin
            o_below_id = r_id[i];
         end
      end
   end

   assign o_depth = r_cnt;
   assign o_full  = (int'(r_cnt) == DEPTH);
   assign o_empty = (r_cnt == '0);

endmodule

// File: rtl/ucc_stack_guard.sv
// ucc_stack_guard
//   Guards nested untrusted-code-container regions: keeps a LIFO of saved
//   frame pointers, checks stack writes, returns, exits and nesting depth,
//   and raises a sticky reset request with the cause of the first violation.
//   Ports:
//     clk, system_reset_n   clock, synchronous active-low reset
//     pc, inst_changed      program counter / new-instruction strobe
//     data_addr, data_wr    data bus write address and strobe
//     stack_pointer         current SP
//     outside_ucc, ucc_id   region membership of pc
//     reset                 registered reset request to the core
//     depth, base_pointer   current nesting depth and top-of-LIFO ebp
//     viol_cause            latched cause of the first violation
module ucc_stack_guard
   import ucc_guard_pkg::*;
#(
   parameter int                ADDR_W        = 16,
   parameter int                DEPTH         = 4,
   parameter int                ID_W          = 3,
   parameter logic [ADDR_W-1:0] RESET_HANDLER = '0,
   parameter logic [ADDR_W-1:0] STACK_FLOOR   = '0
) (
   input  logic                      clk,
   input  logic                      system_reset_n,
   input  logic [ADDR_W-1:0]         pc,
   input  logic                      inst_changed,
   input  logic [ADDR_W-1:0]         data_addr,
   input  logic                      data_wr,
   input  logic [ADDR_W-1:0]         stack_pointer,
   input  logic                      outside_ucc,
   input  logic [ID_W-1:0]           ucc_id,
   output logic                      reset,
   output logic [depth_w(DEPTH)-1:0] depth,
   output logic [ADDR_W-1:0]         base_pointer,
   output logic [2:0]                viol_cause
);

   localparam int CNT_W = depth_w(DEPTH);

   state_t            r_state;
   logic              r_reset;
   cause_t            r_cause;

   state_t            w_state_nxt;
   logic              w_ev_push, w_ev_pop;
   logic              w_wr_bad, w_sp_bad, w_exit_bad, w_ovf, w_viol;
   logic              w_push, w_pop, w_clear, w_reset_nxt;
   cause_t            w_cause, w_cause_nxt;

   logic [ADDR_W-1:0] w_top_ebp;
   logic [ID_W-1:0]   w_top_id, w_below_id;
   logic [CNT_W-1:0]  w_depth;
   logic              w_full, w_empty;

   ebp_lifo #(
      .ADDR_W (ADDR_W),
      .ID_W   (ID_W),
      .DEPTH  (DEPTH)
   ) u_lifo (
      .i_clk      (clk),
      .i_push     (w_push),
      .i_pop      (w_pop),
      .i_clear    (w_clear),
      .i_ebp      (stack_pointer),
      .i_id       (ucc_id),
      .o_top_ebp  (w_top_ebp),
      .o_top_id   (w_top_id),
      .o_below_id (w_below_id),
      .o_depth    (w_depth),
      .o_full     (w_full),
      .o_empty    (w_empty)
   );

   // State register; reset parks the guard in VIOL so the core stays held
   // until it reaches the reset handler.
   always_ff @(posedge clk) begin
      if (!system_reset_n) begin
         r_state <= STATE_VIOL;
         r_reset <= 1'b1;
         r_cause <= CAUSE_NONE;
      end else begin
         r_state <= w_state_nxt;
         r_reset <= w_reset_nxt;
         r_cause <= w_cause_nxt;
      end
   end

   // Next-state: decode region events and rule checks against the
   // pre-update top entry.
   always_comb begin
      w_state_nxt = r_state;
      w_ev_push   = 1'b0;
      w_ev_pop    = 1'b0;
      w_wr_bad    = 1'b0;
      w_sp_bad    = 1'b0;
      w_exit_bad  = 1'b0;
      w_ovf       = 1'b0;
      case (r_state)
         STATE_VIOL: begin
            if (pc == RESET_HANDLER && !data_wr) w_state_nxt = STATE_IDLE;
         end
         STATE_IDLE: begin
            if (inst_changed && !outside_ucc) begin
               w_ev_push   = 1'b1;
               w_state_nxt = STATE_ACTIVE;
            end
         end
         STATE_ACTIVE: begin
            w_wr_bad = !outside_ucc && data_wr &&
                       (data_addr < STACK_FLOOR || data_addr >= w_top_ebp);
            if (inst_changed) begin
               if (outside_ucc) begin
                  w_exit_bad  = (int'(w_depth) != 1);
                  w_sp_bad    = (stack_pointer != w_top_ebp);
                  w_ev_pop    = 1'b1;
                  w_state_nxt = STATE_IDLE;
               end else if (ucc_id != w_top_id) begin
                  // Moving back to the caller's region is a return; any
                  // other new region is a nested call.
                  if (int'(w_depth) >= 2 && ucc_id == w_below_id) begin
                     w_sp_bad = (stack_pointer != w_top_ebp);
                     w_ev_pop = 1'b1;
                  end else begin
                     w_ovf     = w_full;
                     w_ev_push = 1'b1;
                  end
               end
            end
         end
         default: w_state_nxt = STATE_VIOL;
      endcase
      w_viol = w_wr_bad || w_sp_bad || w_exit_bad || w_ovf;
      if (w_viol) w_state_nxt = STATE_VIOL;
   end

   // Outputs: LIFO commands, reset request and cause latching.
   always_comb begin
      w_push  = w_ev_push && !w_viol;
      w_pop   = w_ev_pop && !w_viol;
      w_clear = !system_reset_n || w_viol;

      if (w_wr_bad)        w_cause = CAUSE_WRITE;
      else if (w_sp_bad)   w_cause = CAUSE_SP_MISMATCH;
      else if (w_exit_bad) w_cause = CAUSE_ILLEGAL_EXIT;
      else if (w_ovf)      w_cause = CAUSE_OVERFLOW;
      else                 w_cause = CAUSE_NONE;

      w_reset_nxt = (w_state_nxt == STATE_VIOL);

      // Only the first violation is recorded; leaving VIOL clears it.
      w_cause_nxt = r_cause;
      if (r_state == STATE_VIOL && w_state_nxt == STATE_IDLE)
         w_cause_nxt = CAUSE_NONE;
      else if (w_viol && r_cause == CAUSE_NONE)
         w_cause_nxt = w_cause;
   end

   assign reset        = r_reset;
   assign depth        = w_depth;
   assign base_pointer = w_empty ? '0 : w_top_ebp;
   assign viol_cause   = r_cause;

endmodule

// File: tb/tb_ucc_stack_guard.sv
// tb_ucc_stack_guard
//   Directed scenarios followed by randomized traffic, all checked against a
//   queue-based reference model of the guard's rules.
module tb_ucc_stack_guard;

   localparam logic [15:0] FLOOR = 16'h0200;
   localparam logic [15:0] RH    = 16'h0000;

   logic        clk = 1'b0;
   logic        rst_n, inst, wr, outside;
   logic [15:0] pc, addr, sp;
   logic [2:0]  uid;
   logic        dut_reset;
   logic [1:0]  dut_depth;
   logic [15:0] dut_bp;
   logic [2:0]  dut_cause;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [15:0] ebp;
      logic [2:0]  id;
   } ent_t;

   ent_t q[$];
   bit   m_viol = 1'b1;
   int   m_cause = 0;

   always #5 clk = ~clk;

   ucc_stack_guard #(
      .ADDR_W        (16),
      .DEPTH         (2),
      .ID_W          (3),
      .RESET_HANDLER (RH),
      .STACK_FLOOR   (FLOOR)
   ) dut (
      .clk            (clk),
      .system_reset_n (rst_n),
      .pc             (pc),
      .inst_changed   (inst),
      .data_addr      (addr),
      .data_wr        (wr),
      .stack_pointer  (sp),
      .outside_ucc    (outside),
      .ucc_id         (uid),
      .reset          (dut_reset),
      .depth          (dut_depth),
      .base_pointer   (dut_bp),
      .viol_cause     (dut_cause)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference model: one clock edge worth of the guard rules.
   task automatic model_step();
      logic [15:0] tebp;
      logic [2:0]  tid;
      bit act, bad_wr, bad_sp, bad_exit, ovf, do_push, do_pop;
      int c;
      if (!rst_n) begin
         m_viol = 1'b1; m_cause = 0; q.delete();
         return;
      end
      if (m_viol) begin
         if (pc == RH && !wr) begin m_viol = 1'b0; m_cause = 0; end
         return;
      end
      act  = (q.size() > 0);
      tebp = act ? q[$].ebp : 16'h0;
      tid  = act ? q[$].id  : 3'h0;
      bad_wr = 0; bad_sp = 0; bad_exit = 0; ovf = 0; do_push = 0; do_pop = 0;
      if (act && !outside && wr && !(addr >= FLOOR && addr < tebp)) bad_wr = 1;
      if (inst) begin
         if (!act && !outside) do_push = 1;
         else if (act && outside) begin
            bad_exit = (q.size() != 1);
            bad_sp   = (sp != tebp);
            do_pop   = 1;
         end else if (act && uid != tid) begin
            if (q.size() >= 2 && uid == q[$-1].id) begin
               bad_sp = (sp != tebp);
               do_pop = 1;
            end else begin
               ovf     = (q.size() == 2);
               do_push = 1;
            end
         end
      end
      c = bad_wr ? 1 : bad_sp ? 2 : bad_exit ? 3 : ovf ? 4 : 0;
      if (c != 0) begin
         m_viol = 1'b1;
         q.delete();
         if (m_cause == 0) m_cause = c;
      end else if (do_push) q.push_back('{ebp: sp, id: uid});
      else if (do_pop) void'(q.pop_back());
   endtask

   // One clock: advance the model on the current inputs, then compare.
   task automatic cyc();
      model_step();
      @(posedge clk);
      #1;
      check_eq("reset", 32'(dut_reset), 32'(m_viol));
      check_eq("depth", 32'(dut_depth), 32'(q.size()));
      check_eq("base_pointer", 32'(dut_bp), q.size() > 0 ? 32'(q[$].ebp) : 32'h0);
      check_eq("viol_cause", 32'(dut_cause), 32'(m_cause));
   endtask

   task automatic ev(input logic o, input logic [2:0] id, input logic [15:0] s);
      inst = 1'b1; outside = o; uid = id; sp = s;
      cyc();
      inst = 1'b0;
   endtask

   task automatic wr_at(input logic [15:0] a);
      wr = 1'b1; addr = a;
      cyc();
      wr = 1'b0;
   endtask

   task automatic recover();
      outside = 1'b1; inst = 1'b0; wr = 1'b0; pc = RH;
      cyc();
      check_eq("recover_reset", 32'(dut_reset), 32'h0);
      check_eq("recover_cause", 32'(dut_cause), 32'h0);
      pc = 16'h1000;
   endtask

   initial begin
      logic [15:0] top;
      rst_n = 1'b0; pc = 16'h1000; inst = 1'b0; addr = 16'h0; wr = 1'b0;
      sp = 16'h0; outside = 1'b1; uid = 3'd0;

      // Power-up: held in reset, released at the handler.
      cyc();
      cyc();
      check_eq("pwr_reset", 32'(dut_reset), 32'h1);
      check_eq("pwr_depth", 32'(dut_depth), 32'h0);
      check_eq("pwr_cause", 32'(dut_cause), 32'h0);
      rst_n = 1'b1;
      recover();

      // Single entry, legal write, legal exit.
      ev(1'b0, 3'd1, 16'h0400);
      check_eq("enter_depth", 32'(dut_depth), 32'h1);
      check_eq("enter_bp", 32'(dut_bp), 32'h0400);
      wr_at(16'h03FE);
      check_eq("ok_write", 32'(dut_reset), 32'h0);
      ev(1'b1, 3'd0, 16'h0400);
      check_eq("exit_depth", 32'(dut_depth), 32'h0);
      check_eq("exit_reset", 32'(dut_reset), 32'h0);

      // Write at ebp, then below the floor.
      ev(1'b0, 3'd1, 16'h0400);
      wr_at(16'h0400);
      check_eq("wr_at_ebp_reset", 32'(dut_reset), 32'h1);
      check_eq("wr_at_ebp_cause", 32'(dut_cause), 32'h1);
      recover();
      ev(1'b0, 3'd1, 16'h0400);
      wr_at(16'h01FE);
      check_eq("wr_floor_cause", 32'(dut_cause), 32'h1);
      recover();

      // Nested call / return, then return with wrong SP.
      ev(1'b0, 3'd1, 16'h0400);
      ev(1'b0, 3'd2, 16'h03F0);
      check_eq("call_depth", 32'(dut_depth), 32'h2);
      check_eq("call_bp", 32'(dut_bp), 32'h03F0);
      ev(1'b0, 3'd1, 16'h03F0);
      check_eq("ret_depth", 32'(dut_depth), 32'h1);
      check_eq("ret_bp", 32'(dut_bp), 32'h0400);
      ev(1'b0, 3'd2, 16'h03F0);
      ev(1'b0, 3'd1, 16'h03EE);
      check_eq("ret_sp_cause", 32'(dut_cause), 32'h2);
      recover();

      // Overflow at DEPTH=2, then illegal exit from depth 2.
      ev(1'b0, 3'd1, 16'h0400);
      ev(1'b0, 3'd2, 16'h03F0);
      ev(1'b0, 3'd3, 16'h03E0);
      check_eq("ovf_cause", 32'(dut_cause), 32'h4);
      recover();
      ev(1'b0, 3'd1, 16'h0400);
      ev(1'b0, 3'd2, 16'h03F0);
      ev(1'b1, 3'd0, 16'h03F0);
      check_eq("illexit_cause", 32'(dut_cause), 32'h3);
      recover();

      // Bad write alongside an SP-mismatched return: WRITE wins.
      ev(1'b0, 3'd1, 16'h0400);
      ev(1'b0, 3'd2, 16'h03F0);
      wr = 1'b1; addr = 16'h03F0;
      ev(1'b0, 3'd1, 16'h03E0);
      wr = 1'b0;
      check_eq("prio_cause", 32'(dut_cause), 32'h1);
      recover();

      // Reset while nested.
      ev(1'b0, 3'd1, 16'h0400);
      ev(1'b0, 3'd2, 16'h03F0);
      rst_n = 1'b0;
      cyc();
      check_eq("midrst_depth", 32'(dut_depth), 32'h0);
      check_eq("midrst_reset", 32'(dut_reset), 32'h1);
      check_eq("midrst_bp", 32'(dut_bp), 32'h0);
      rst_n = 1'b1;
      recover();

      // Randomized traffic biased toward the interesting addresses.
      for (int n = 0; n < 800; n++) begin
         top = (q.size() > 0) ? q[$].ebp : 16'h0400;
         rst_n   = ($urandom_range(0, 63) != 0);
         pc      = ($urandom_range(0, 3) == 0) ? RH : 16'($urandom);
         inst    = $urandom_range(0, 1) == 1;
         outside = ($urandom_range(0, 4) == 0);
         uid     = 3'($urandom_range(1, 3));
         wr      = ($urandom_range(0, 3) == 0);
         case ($urandom_range(0, 3))
            0:       addr = top - 16'd2;
            1:       addr = top;
            2:       addr = FLOOR - 16'd2;
            default: addr = 16'($urandom);
         endcase
         case ($urandom_range(0, 3))
            0:       sp = top;
            1:       sp = top - 16'h0010;
            2:       sp = top - 16'd2;
            default: sp = 16'h0300 + 16'($urandom_range(0, 255));
         endcase
         cyc();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
